// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction prefetch unit
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
    localparam int          INST_W           = 32;

    // Field order of a queue entry, most significant first.
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
        logic              adef;
    } if_entry_t;

    function automatic int entry_w(input int addr_w);
        return addr_w + INST_W + 1;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - DEPTH-entry fetch queue with push, pop, flush and head output
module if_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Payload needs no reset: it is only observed while count is nonzero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction fetch front end: PC, SRAM request, inflight tracking, queue
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              inst_sram_en,
    output logic              inst_sram_we,
    output logic [ADDR_W-1:0] inst_sram_addr,
    output logic [31:0]       inst_sram_wdata,
    input  logic [31:0]       inst_sram_rdata,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              fs_valid,
    output logic [ADDR_W-1:0] fs_pc,
    output logic [31:0]       fs_inst,
    output logic              fs_adef,
    input  logic              ds_allowin
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EW    = entry_w(ADDR_W);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              inflight_adef;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;

    // Credit includes the inflight request so its response always has a slot.
    assign credit_used = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue       = ~reset & ~br_taken & (credit_used < (CNT_W+1)'(DEPTH));

    assign push     = inflight & ~br_taken;
    assign fs_valid = (count != '0);
    assign pop      = fs_valid & ds_allowin & ~br_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            inflight_adef <= 1'b0;
        end else if (br_taken) begin
            fetch_pc <= br_target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc   <= fetch_pc;
                inflight_adef <= (fetch_pc[1:0] != 2'b00);
                fetch_pc      <= fetch_pc + ADDR_W'(4);
            end
        end
    end

    if_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({inflight_pc, inst_sram_rdata, inflight_adef}),
        .pop   (pop),
        .flush (br_taken),
        .head  (head),
        .count (count)
    );

    assign inst_sram_en    = issue;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = 32'h0;

    assign fs_pc   = head[EW-1 -: ADDR_W];
    assign fs_inst = head[INST_W:1];
    assign fs_adef = head[0];

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - cycle table plus scoreboard bench for if_prefetch_unit
module tb_if_prefetch_unit;
    import if_pkg::*;

    localparam logic [31:0] B   = 32'h1c000000;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adef;
    logic        ds_allowin = 1'b0;

    if_prefetch_unit #(
        .ADDR_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h1c000000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .fs_valid        (fs_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst),
        .fs_adef         (fs_adef),
        .ds_allowin      (ds_allowin)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM with one-cycle read latency; contents derived from address.
    always @(posedge clk) inst_sram_rdata <= inst_sram_addr ^ KEY;

    typedef struct {
        logic        rst;
        logic        al;
        logic        br;
        logic [31:0] tgt;
        logic        en;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic        adef;
    } vec_t;

    vec_t      tbl[$];
    if_entry_t sb[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic al, input logic br, input logic [31:0] tgt,
                       input logic en, input logic [31:0] addr, input logic v, input logic [31:0] pc);
        vec_t r;
        r.rst = rst; r.al = al; r.br = br; r.tgt = tgt;
        r.en = en; r.addr = addr; r.v = v; r.pc = pc;
        r.adef = (pc[1:0] != 2'b00);
        tbl.push_back(r);
    endtask

    task automatic apply(input int row, input vec_t r);
        if_entry_t e;
        @(negedge clk);
        reset      = r.rst;
        ds_allowin = r.al;
        br_taken   = r.br;
        br_target  = r.tgt;
        #1;
        chk("sram_en", row, 32'(inst_sram_en), 32'(r.en));
        if (r.en) chk("sram_addr", row, inst_sram_addr, r.addr);
        chk("fs_valid", row, 32'(fs_valid), 32'(r.v));
        if (r.v) begin
            chk("fs_pc", row, fs_pc, r.pc);
            chk("fs_adef", row, 32'(fs_adef), 32'(r.adef));
        end
        if (reset) begin
            sb.delete();
        end else begin
            if (fs_valid && ds_allowin && !br_taken) begin
                if (sb.size() == 0) begin
                    chk("sb_underrun", row, fs_pc, 32'hxxxxxxxx);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", row, fs_pc, e.pc);
                    chk("sb_inst", row, fs_inst, e.inst);
                    chk("sb_adef", row, 32'(fs_adef), 32'(e.adef));
                end
            end
            if (br_taken) sb.delete();
            if (inst_sram_en) begin
                e.pc   = inst_sram_addr;
                e.inst = inst_sram_addr ^ KEY;
                e.adef = (inst_sram_addr[1:0] != 2'b00);
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst al br tgt en addr v pc
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // free run: first head two cycles after first request, then one per cycle
        add(0, 1, 0, 0, 1, B+'h00, 0, 0);
        add(0, 1, 0, 0, 1, B+'h04, 0, 0);
        add(0, 1, 0, 0, 1, B+'h08, 1, B+'h00);
        add(0, 1, 0, 0, 1, B+'h0c, 1, B+'h04);
        add(0, 1, 0, 0, 1, B+'h10, 1, B+'h08);
        // stall from reset: four requests then credit exhausted
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, B+'h00, 0, 0);
        add(0, 0, 0, 0, 1, B+'h04, 0, 0);
        add(0, 0, 0, 0, 1, B+'h08, 1, B+'h00);
        add(0, 0, 0, 0, 1, B+'h0c, 1, B+'h00);
        add(0, 0, 0, 0, 0, 0, 1, B+'h00);
        add(0, 0, 0, 0, 0, 0, 1, B+'h00);
        add(0, 0, 0, 0, 0, 0, 1, B+'h00);
        add(0, 1, 0, 0, 0, 0, 1, B+'h00);
        add(0, 1, 0, 0, 1, B+'h10, 1, B+'h04);
        add(0, 1, 0, 0, 1, B+'h14, 1, B+'h08);
        add(0, 1, 0, 0, 1, B+'h18, 1, B+'h0c);
        add(0, 1, 0, 0, 1, B+'h1c, 1, B+'h10);
        // three queued + one inflight, then redirect coinciding with pop and capture
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, B+'h00, 0, 0);
        add(0, 0, 0, 0, 1, B+'h04, 0, 0);
        add(0, 0, 0, 0, 1, B+'h08, 1, B+'h00);
        add(0, 0, 0, 0, 1, B+'h0c, 1, B+'h00);
        add(0, 1, 1, B+'h100, 0, 0, 1, B+'h00);
        add(0, 1, 0, 0, 1, B+'h100, 0, 0);
        add(0, 1, 0, 0, 1, B+'h104, 0, 0);
        add(0, 1, 0, 0, 1, B+'h108, 1, B+'h100);
        add(0, 1, 0, 0, 1, B+'h10c, 1, B+'h104);
        // misaligned redirect target
        add(0, 1, 1, B+'h102, 0, 0, 1, B+'h108);
        add(0, 1, 0, 0, 1, B+'h102, 0, 0);
        add(0, 1, 0, 0, 1, B+'h106, 0, 0);
        add(0, 1, 0, 0, 1, B+'h10a, 1, B+'h102);
        add(0, 1, 0, 0, 1, B+'h10e, 1, B+'h106);
        // build two queued + one inflight, then reset mid-operation
        add(0, 0, 0, 0, 1, B+'h112, 1, B+'h10a);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, B+'h00, 0, 0);
        add(0, 1, 0, 0, 1, B+'h04, 0, 0);
        add(0, 1, 0, 0, 1, B+'h08, 1, B+'h00);
        add(0, 1, 0, 0, 1, B+'h0c, 1, B+'h04);

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        chk("sram_we", -1, 32'(inst_sram_we), 32'h0);
        chk("sram_wdata", -1, inst_sram_wdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Parametrised instruction-fetch front end for the pipelined successor of the single-cycle LoongArch core. It drives the synchronous instruction SRAM (1-cycle read latency) from its own PC register and buffers returned {pc, inst} pairs in a DEPTH-entry queue. It presents them to decode through a valid/allowin handshake. Taken branches and jumps redirect fetch, flush the queue and discard the in-flight response.

## Interface

Parameters:
- ADDR_W, 32, PC and SRAM address width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- inst_sram_en  out  1  read request this cycle.
- inst_sram_we  out  1  tied 0.
- inst_sram_addr  out  ADDR_W  request address (= fetch_pc).
- inst_sram_wdata  out  32  tied 0.
- inst_sram_rdata  in  32  data for the request issued in the previous cycle.
- br_taken  in  1  redirect strobe from decode/execute.
- br_target  in  ADDR_W  redirect address, sampled when br_taken=1.
- fs_valid  out  1  queue head valid.
- fs_pc  out  ADDR_W  head PC.
- fs_inst  out  32  head instruction.
- fs_adef  out  1  head PC misaligned (pc[1:0]≠0).
- ds_allowin  in  1  decode accepts head this cycle.

## Operation

- State: fetch_pc (ADDR_W), inflight (1 bit), inflight_pc, inflight_adef, queue of DEPTH entries {pc, inst, adef}, rd_ptr/wr_ptr ($clog2(DEPTH) bits, natural wrap), count ($clog2(DEPTH+1) bits).
- Issue: inst_sram_en = ~br_taken & (count + inflight < DEPTH).
  - On issue: inflight←1, inflight_pc←fetch_pc, inflight_adef←(fetch_pc[1:0]≠0), fetch_pc←fetch_pc+4 (mod 2^ADDR_W).
  - Otherwise inflight←0.
- Capture: if inflight=1 and no redirect this cycle, write {inflight_pc, inst_sram_rdata, inflight_adef} at wr_ptr and advance wr_ptr.
- Pop: fs_valid & ds_allowin & ~br_taken advances rd_ptr.
- count updates by +capture −pop; simultaneous capture and pop leaves count unchanged.
- fs_valid = (count≠0). fs_pc, fs_inst and fs_adef are the head entry; their values are don't-care when fs_valid=0.
- Redirect (br_taken=1): next cycle count=0, rd_ptr=wr_ptr=0, inflight=0, fetch_pc=br_target.
  - The current-cycle response and any pop are dropped.
  - No request is issued in the redirect cycle.
- Misaligned target: the request is still issued with that address; the entry carries fs_adef=1. Fetch continues at +4.
- Overflow cannot occur, because the issue credit counts inflight. Underflow cannot occur, because pop is gated by fs_valid.

## Timing

- Reset values: inst_sram_en=0, fs_valid=0, fetch_pc=RESET_PC, count=0, inflight=0, pointers=0.
- First cycle after reset deasserts: request RESET_PC. Head valid 2 cycles later.
- Issue-to-fs_valid latency: 2 cycles (request at t, SRAM data at t+1 written into the queue, fs_valid at t+2). There is no bypass path.
- Redirect at cycle t: request br_target at t+1; fs_valid with pc=br_target at t+3.
- Sustained throughput: 1 instruction/cycle while ds_allowin=1.
- ds_allowin=0: the queue fills to DEPTH, then inst_sram_en=0 until pops free credit.
- Reset mid-operation: all state clears asynchronously. A response arriving after reset is ignored.

## Structure

- Package if_pkg holds:
  - RESET_PC default.
  - typedef if_entry_t {pc, inst, adef}.
  - Width helper localparams.
- Sub-module if_fifo: synchronous DEPTH-entry queue with push, pop, flush, count and head outputs. The parent holds the fetch PC, the inflight tracking and the issue credit.

## Test plan

- Reset then free run, ds_allowin=1, rdata=addr^32'hA5A5A5A5 → requests 1c000000, 1c000004, …; fs_pc=1c000000 appears 2 cycles after the first request; then one instruction per cycle with no gaps.
- ds_allowin=0 from start, DEPTH=4 → exactly 4 requests issue, count=4, inst_sram_en stays 0; raise ds_allowin → heads pop in order 1c000000 to 1c00000c and fetch resumes at 1c000010.
- br_taken with target 1c000100 while the queue holds 3 entries and one request is inflight → fs_valid=0 the next cycle; request 1c000100 at t+1; fs_pc=1c000100 at t+3; no stale PC ever appears.
- br_taken asserted in the same cycle as a pop and a capture → neither takes effect; count=0 afterwards.
- Redirect to 1c000102 → the entry shows fs_adef=1 with fs_pc=1c000102; the following entry is 1c000106 with fs_adef=1.
- Assert reset with 2 entries queued and a request inflight → fs_valid and inst_sram_en drop immediately; after release, fetch restarts at RESET_PC.
